voltage_text_buffer: RTL and testbench

Parametrised, live successor to the fixed channel-label text ROM. Serves one 7-bit ASCII character per text address to the 16x16 character renderer, with per-channel rows `V<nn> - <dddd> V`. The `<dddd>` field comes from measured channel values: the block converts each accepted binary value to decimal with a sequential double-dabble engine and stores the digits per channel. Sits between the ADC sequencer (value producer) and the text/char-ROM pipeline of the VGA display path.

---
 rtl/vtb_pkg.sv | 35 +++
 rtl/bin2bcd_seq.sv | 71 +++++++
 rtl/voltage_text_buffer.sv | 138 +++++++++++++
 tb/tb_voltage_text_buffer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vtb_pkg.sv
// Shared constants for voltage_text_buffer: ASCII codes, row layout offsets,
// FSM state encoding and a small power-of-ten helper.
package vtb_pkg;

    localparam logic [6:0] ASC_V     = 7'h56;
    localparam logic [6:0] ASC_SPACE = 7'h20;
    localparam logic [6:0] ASC_DASH  = 7'h2D;
    localparam logic [6:0] ASC_ZERO  = 7'h30;

    // Character offsets inside one channel row
    localparam int OFF_HEAD_V = 0;
    localparam int OFF_TENS   = 1;
    localparam int OFF_UNITS  = 2;
    localparam int OFF_SP0    = 3;
    localparam int OFF_DASH   = 4;
    localparam int OFF_SP1    = 5;
    localparam int OFF_DIG    = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WRITE = 2'd2
    } vtb_state_e;

    // 10^n for the small digit counts used here (n <= 5)
    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int i = 0; i < 5; i++) begin
            if (i < n) r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one shift/add-3 step per cycle,
// VAL_W steps after start_i. bcd_o holds DIGITS nibbles, nibble 0 = LSD.
// done_o is high in the cycle whose edge performs the final step.
module bin2bcd_seq
    import vtb_pkg::*;
#(
    parameter int VAL_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [VAL_W-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DIGITS*4-1:0]   bcd_o
);

    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0]    bin_q, bin_d;
    logic [DIGITS*4-1:0] bcd_q, bcd_d;
    logic [DIGITS*4-1:0] adj;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;

    // Next-state: load on start, otherwise add-3 correct then shift one bit in
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            bin_d  = bin_i;
            bcd_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            bcd_d = {adj[DIGITS*4-2:0], bin_q[VAL_W-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(VAL_W - 1)) busy_d = 1'b0;
        end
    end

    // Control registers: step counter and busy flag
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // Datapath registers: shift source and BCD accumulator
    always_ff @(posedge clk_i) begin
        bin_q <= bin_d;
        bcd_q <= bcd_d;
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == CNT_W'(VAL_W - 1));
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/voltage_text_buffer.sv
// Live channel-label text source for the 16x16 character renderer.
// Each row reads "V<nn> - <digits> V"; digits come from values accepted on
// the val_* handshake, converted to BCD and stored per channel.
// Optional macro VTB_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module voltage_text_buffer
    import vtb_pkg::*;
#(
    parameter int CHANNELS  = 13,
    parameter int VAL_W     = 12,
    parameter int DIGITS    = 4,
    parameter int ROW_CHARS = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        text_xy,
    output logic [6:0]        char_code,
    input  logic              val_valid,
    input  logic [3:0]        val_ch,
    input  logic [VAL_W-1:0]  val_data,
    output logic              val_ready
);

    vtb_state_e          state_q, state_d;
    logic [3:0]          ch_q;
    logic                sat_q;
    logic [DIGITS*4-1:0] store_q [CHANNELS];
    logic [6:0]          char_code_q, char_code_d;

    logic                xfer, start, write_en;
    logic                eng_busy, eng_done;
    logic [DIGITS*4-1:0] eng_bcd;

    assign val_ready = rst_n && (state_q == ST_IDLE);
    assign xfer      = val_valid && val_ready;
    // Out-of-range channels complete the handshake but are dropped here
    assign start     = xfer && (int'(val_ch) < CHANNELS);

    bin2bcd_seq #(
        .VAL_W  (VAL_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start),
        .bin_i   (val_data),
        .busy_o  (eng_busy),
        .done_o  (eng_done),
        .bcd_o   (eng_bcd)
    );

    // FSM next state: IDLE -> SHIFT on accepted value, SHIFT -> WRITE on last step
    always_comb begin
        state_d  = state_q;
        write_en = 1'b0;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (eng_done) state_d = ST_WRITE;
            ST_WRITE: begin
                write_en = !eng_busy;
                state_d  = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Capture target channel and saturation decision at the transfer edge
    always_ff @(posedge clk) begin
        if (start) begin
            ch_q  <= val_ch;
            sat_q <= 32'(val_data) > (pow10(DIGITS) - 1);
        end
    end

    // Digit store: cleared by reset, whole channel written in the WRITE cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) store_q[c] <= '0;
        end else if (write_en) begin
            store_q[ch_q] <= sat_q ? {DIGITS{4'd9}} : eng_bcd;
        end
    end

    // Read mux: decode text_xy into row/offset and pick the character
    always_comb begin
        int                  row_i;
        int                  off_i;
        logic [3:0]          row_idx;
        logic [DIGITS*4-1:0] digs;
        logic [3:0]          nib;
        logic                lz;

        char_code_d = ASC_SPACE;
        row_i       = 0;
        off_i       = 0;
        row_idx     = '0;
        digs        = '0;
        nib         = '0;
        lz          = 1'b1;
        if (int'(text_xy) < CHANNELS * ROW_CHARS) begin
            row_i   = int'(text_xy) / ROW_CHARS;
            off_i   = int'(text_xy) % ROW_CHARS;
            row_idx = row_i[3:0];
            digs    = store_q[row_idx];
            if (off_i == OFF_HEAD_V)              char_code_d = ASC_V;
            else if (off_i == OFF_TENS)           char_code_d = ASC_ZERO + 7'((row_i + 1) / 10);
            else if (off_i == OFF_UNITS)          char_code_d = ASC_ZERO + 7'((row_i + 1) % 10);
            else if (off_i == OFF_DASH)           char_code_d = ASC_DASH;
            else if (off_i == OFF_DIG + DIGITS + 1) char_code_d = ASC_V;
            for (int d = 0; d < DIGITS; d++) begin
                nib = digs[4*(DIGITS-1-d) +: 4];
                if (nib != 4'd0) lz = 1'b0;
                if (off_i == OFF_DIG + d) begin
`ifdef VTB_LEADING_ZERO_BLANK_EN
                    if (lz && (d != DIGITS - 1)) char_code_d = ASC_SPACE;
                    else                         char_code_d = ASC_ZERO + {3'b000, nib};
`else
                    char_code_d = ASC_ZERO + {3'b000, nib};
`endif
                end
            end
        end
    end

    // Registered character output, one cycle behind text_xy
    always_ff @(posedge clk) begin
        if (!rst_n) char_code_q <= ASC_SPACE;
        else        char_code_q <= char_code_d;
    end

    assign char_code = char_code_q;

endmodule

// File: tb/tb_voltage_text_buffer.sv
// Directed, table-driven bench for voltage_text_buffer (default parameters)
// plus a DIGITS=3 instance for the saturation corner.
module tb_voltage_text_buffer;

    localparam int VAL_W = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  text_xy;
    logic [6:0]  char_code;
    logic        val_valid;
    logic [3:0]  val_ch;
    logic [11:0] val_data;
    logic        val_ready;
    logic [7:0]  text_xy3;
    logic [6:0]  char_code3;
    logic        val_ready3;

    always #5 clk = ~clk;

    voltage_text_buffer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .text_xy   (text_xy),
        .char_code (char_code),
        .val_valid (val_valid),
        .val_ch    (val_ch),
        .val_data  (val_data),
        .val_ready (val_ready)
    );

    voltage_text_buffer #(
        .CHANNELS  (13),
        .VAL_W     (12),
        .DIGITS    (3),
        .ROW_CHARS (11)
    ) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .text_xy   (text_xy3),
        .char_code (char_code3),
        .val_valid (val_valid),
        .val_ch    (val_ch),
        .val_data  (val_data),
        .val_ready (val_ready3)
    );

    typedef struct {
        logic [7:0] addr;
        logic [6:0] exp;
    } vec_t;

    vec_t  tbl[$];
    int    nvec  = 0;
    int    nfail = 0;
    string row1_0, row1_89, row4_0, row13_0;

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_row(input int base, input string s);
        for (int i = 0; i < s.len(); i++)
            tbl.push_back('{addr: 8'(base + i), exp: 7'(s[i])});
    endtask

    task automatic add_one(input int addr, input int exp);
        tbl.push_back('{addr: 8'(addr), exp: 7'(exp)});
    endtask

    // Each vector: present address after an edge, compare one edge later
    task automatic run_table(input string name);
        foreach (tbl[i]) begin
            text_xy = tbl[i].addr;
            @(posedge clk); #1;
            check($sformatf("%s[0x%0h]", name, tbl[i].addr), char_code, tbl[i].exp);
        end
        tbl.delete();
    endtask

    // Transfer on the next edge; returns #1 after that edge
    task automatic xfer(input logic [3:0] ch, input logic [11:0] d);
        val_valid = 1'b1;
        val_ch    = ch;
        val_data  = d;
        @(posedge clk); #1;
        val_valid = 1'b0;
    endtask

    // Count sampled cycles with val_ready low, bounded
    task automatic wait_ready(output int lows);
        lows = 0;
        while (!val_ready && lows < 100) begin
            lows++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    lows;
        string s3;

`ifdef VTB_LEADING_ZERO_BLANK_EN
        row1_0  = "V01 -    0 V";
        row1_89 = "V01 -   89 V";
        row4_0  = "V04 -    0 V";
        row13_0 = "V13 -    0 V";
`else
        row1_0  = "V01 - 0000 V";
        row1_89 = "V01 - 0089 V";
        row4_0  = "V04 - 0000 V";
        row13_0 = "V13 - 0000 V";
`endif

        rst_n     = 1'b0;
        text_xy   = 8'h00;
        text_xy3  = 8'h00;
        val_valid = 1'b0;
        val_ch    = '0;
        val_data  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_char_code", char_code, 'h20);
        check("rst_val_ready", val_ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", val_ready, 1);

        // Empty store, out-of-range addresses
        add_row(0, row1_0);
        add_row(144, row13_0);
        add_one(8'h9C, 'h20);
        add_one(8'hA0, 'h20);
        add_one(8'hFF, 'h20);
        run_table("empty");

        // ch 0 <- 89; ready low VAL_W+1 sampled cycles so the next
        // transfer can land VAL_W+2 edges after this one
        xfer(4'd0, 12'd89);
        wait_ready(lows);
        check("busy_len_89", lows, VAL_W + 1);
        add_row(0, row1_89);
        run_table("ch0_89");

        // ch 12 <- 4095: full value with 4 digits, saturates with 3 digits
        xfer(4'd12, 12'd4095);
        wait_ready(lows);
        check("busy_len_4095", lows, VAL_W + 1);
        check("ready3_4095", val_ready3, 1);
        add_row(144, "V13 - 4095 V");
        run_table("ch12_4095");
        s3 = "V13 - 999 V";
        for (int i = 0; i < s3.len(); i++) begin
            text_xy3 = 8'(132 + i);
            @(posedge clk); #1;
            check($sformatf("sat3[%0d]", i), char_code3, 7'(s3[i]));
        end

        // Illegal channel: handshake completes, nothing changes
        val_valid = 1'b1;
        val_ch    = 4'd13;
        val_data  = 12'd555;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("ch13_ready[%0d]", i), val_ready, 1);
        end
        val_valid = 1'b0;
        add_row(0, row1_89);
        add_row(144, "V13 - 4095 V");
        run_table("ch13_nochange");

        // Continuous read of the LSD of ch 0 across a write of 7
        text_xy = 8'h09;
        xfer(4'd0, 12'd7);
        check("cont_k", char_code, 'h39);
        for (int j = 1; j <= VAL_W + 1; j++) begin
            @(posedge clk); #1;
            check($sformatf("cont_old[%0d]", j), char_code, 'h39);
        end
        check("cont_ready", val_ready, 1);
        @(posedge clk); #1;
        check("cont_new", char_code, 'h37);

        // Reset pulse mid-conversion of ch 3 <- 1234
        xfer(4'd3, 12'd1234);
        repeat (5) @(posedge clk);
        #1;
        check("midshift_busy", val_ready, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_char", char_code, 'h20);
        check("midrst_ready", val_ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_ready", val_ready, 1);
        repeat (20) @(posedge clk);
        #1;
        add_row(36, row4_0);
        add_row(0, row1_0);
        add_row(144, row13_0);
        run_table("after_abort");

        xfer(4'd3, 12'd1234);
        wait_ready(lows);
        check("busy_len_1234", lows, VAL_W + 1);
        add_row(36, "V04 - 1234 V");
        run_table("ch3_1234");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
